// File: rtl/cv32e40px_register_file_sb.sv
// cv32e40px_register_file_sb: multi-read-port register file with optional forwarding
// and a pending-write scoreboard for offloaded instruction destinations.
module cv32e40px_register_file_sb #(
    parameter int ADDR_WIDTH  = 6,
    parameter int DATA_WIDTH  = 32,
    parameter int FPU         = 0,
    parameter int ZFINX       = 0,
    parameter int NUM_READ    = 3,
    parameter int X_DUALWRITE = 0,
    parameter int FORWARD     = 0,
    parameter int MAX_PENDING = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_READ-1:0][ADDR_WIDTH-1:0]   raddr_i,
    output logic [NUM_READ-1:0][DATA_WIDTH-1:0]   rdata_o,
    output logic [NUM_READ-1:0]                   rbusy_o,
    input  logic [ADDR_WIDTH-1:0]                 waddr_a_i,
    input  logic [DATA_WIDTH-1:0]                 wdata_a_i,
    input  logic                                  we_a_i,
    input  logic [ADDR_WIDTH-1:0]                 waddr_b_i,
    input  logic [X_DUALWRITE:0][DATA_WIDTH-1:0]  wdata_b_i,
    input  logic [X_DUALWRITE:0]                  we_b_i,
    input  logic                                  reserve_valid_i,
    output logic                                  reserve_ready_o,
    input  logic [ADDR_WIDTH-1:0]                 reserve_addr_i,
    input  logic                                  reserve_pair_i,
    output logic [$clog2(MAX_PENDING+1)-1:0]      pending_cnt_o,
    output logic                                  err_o
);
    localparam bit FPB     = (FPU != 0) && (ZFINX == 0);
    localparam int IW      = FPB ? ADDR_WIDTH : ADDR_WIDTH - 1;
    localparam int NUM_TOT = 2 ** IW;
    localparam int CW      = $clog2(MAX_PENDING + 1);

    logic [DATA_WIDTH-1:0] mem [NUM_TOT];
    logic [NUM_TOT-1:0]    busy, busy_nxt, a_hit, b0_hit, b1_hit, b_hit, rsv_set;
    logic [CW-1:0]         cnt_nxt;
    logic [CW:0]           n_tgt;
    logic                  we_b1, pair_rsv, ok0, ok1, rsv_hit, err_set, rok, fa, fb;
    logic [IW-1:0]         ri;
    logic [DATA_WIDTH-1:0] wdata_b1;
    logic [ADDR_WIDTH-1:0] waddr_b1, rsv_addr1;

    // Writable/readable: not x0 and inside an instantiated bank
    function automatic logic ok(input logic [ADDR_WIDTH-1:0] a);
        return (a != '0) && (FPB || !a[ADDR_WIDTH-1]);
    endfunction

    function automatic logic [IW-1:0] idx(input logic [ADDR_WIDTH-1:0] a);
        return a[IW-1:0];
    endfunction

    assign waddr_b1  = waddr_b_i | ADDR_WIDTH'(1);
    assign rsv_addr1 = reserve_addr_i | ADDR_WIDTH'(1);
    assign we_b1     = (X_DUALWRITE != 0) && we_b_i[X_DUALWRITE] && !waddr_b_i[0];
    assign wdata_b1  = wdata_b_i[X_DUALWRITE];

    always_comb begin
        pair_rsv = (X_DUALWRITE != 0) && reserve_pair_i && !reserve_addr_i[0];
        ok0      = ok(reserve_addr_i);
        ok1      = pair_rsv && ok(rsv_addr1);
        rsv_hit  = (ok0 && busy[idx(reserve_addr_i)]) || (ok1 && busy[idx(rsv_addr1)]);
        n_tgt    = (CW+1)'(ok0) + (CW+1)'(ok1);
        // Ready depends on registered state only; same-cycle clears do not free slots
        reserve_ready_o = !rst && !rsv_hit && (({1'b0, pending_cnt_o} + n_tgt) <= (CW+1)'(MAX_PENDING));
        a_hit   = '0;
        b0_hit  = '0;
        b1_hit  = '0;
        rsv_set = '0;
        for (int r = 0; r < NUM_TOT; r++) begin
            a_hit[r]   = we_a_i && ok(waddr_a_i) && (idx(waddr_a_i) == IW'(r));
            b0_hit[r]  = we_b_i[0] && ok(waddr_b_i) && (idx(waddr_b_i) == IW'(r));
            b1_hit[r]  = we_b1 && ok(waddr_b1) && (idx(waddr_b1) == IW'(r));
            rsv_set[r] = reserve_valid_i && reserve_ready_o &&
                         ((ok0 && idx(reserve_addr_i) == IW'(r)) || (ok1 && idx(rsv_addr1) == IW'(r)));
        end
        b_hit    = b0_hit | b1_hit;
        busy_nxt = (busy & ~b_hit) | rsv_set;
        err_set  = |((b_hit & ~busy) | (a_hit & busy) | (a_hit & b_hit));
        cnt_nxt  = '0;
        for (int r = 0; r < NUM_TOT; r++)
            cnt_nxt = cnt_nxt + CW'(busy_nxt[r]);
    end

    always_comb begin
        rdata_o = '0;
        rbusy_o = '0;
        ri      = '0;
        rok     = 1'b0;
        fa      = 1'b0;
        fb      = 1'b0;
        for (int k = 0; k < NUM_READ; k++) begin
            ri  = idx(raddr_i[k]);
            rok = ok(raddr_i[k]);
            fb  = (FORWARD != 0) && !rst && rok && b_hit[ri];
            fa  = (FORWARD != 0) && !rst && rok && a_hit[ri];
            rdata_o[k] = fb ? (b1_hit[ri] ? wdata_b1 : wdata_b_i[0]) :
                         fa ? wdata_a_i : rok ? mem[ri] : '0;
            rbusy_o[k] = rok && busy[ri] && !fb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_TOT; r++)
                mem[r] <= '0;
            busy          <= '0;
            pending_cnt_o <= '0;
            err_o         <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_TOT; r++)
                if (b_hit[r])
                    mem[r] <= b1_hit[r] ? wdata_b1 : wdata_b_i[0];
                else if (a_hit[r])
                    mem[r] <= wdata_a_i;
            busy          <= busy_nxt;
            pending_cnt_o <= cnt_nxt;
            err_o         <= err_o | err_set;
        end
    end
endmodule

// File: tb/tb_cv32e40px_register_file_sb.sv
// tb_cv32e40px_register_file_sb: scoreboard bench driving a non-forwarding and a
// forwarding instance with the same directed stimulus.
module tb_cv32e40px_register_file_sb;
    localparam int RD = 0, BZ = 1, RDY = 2, CNT = 3, ERR = 4;

    typedef struct {
        string       name;
        int          dut;
        int          sel;
        int          port;
        logic [31:0] exp;
        int          cyc;
    } chk_t;

    logic clk = 1'b0, rst = 1'b1;
    logic [2:0][5:0]  raddr = '0;
    logic [5:0]       waddr_a = '0, waddr_b = '0, rsv_addr = '0;
    logic [31:0]      wdata_a = '0;
    logic [1:0][31:0] wdata_b = '0;
    logic [1:0]       we_b = '0;
    logic             we_a = 1'b0, rsv_valid = 1'b0, rsv_pair = 1'b0;
    logic [2:0][31:0] rdata0, rdata1;
    logic [2:0]       rbusy0, rbusy1;
    logic             ready0, ready1, err0, err1;
    logic [2:0]       cnt0, cnt1;
    int               cyc = 0, total = 0, bad = 0;
    chk_t             q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cv32e40px_register_file_sb #(.X_DUALWRITE(1), .FORWARD(0), .MAX_PENDING(4)) d0 (
        .clk(clk), .rst(rst), .raddr_i(raddr), .rdata_o(rdata0), .rbusy_o(rbusy0),
        .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
        .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b),
        .reserve_valid_i(rsv_valid), .reserve_ready_o(ready0), .reserve_addr_i(rsv_addr),
        .reserve_pair_i(rsv_pair), .pending_cnt_o(cnt0), .err_o(err0));

    cv32e40px_register_file_sb #(.X_DUALWRITE(1), .FORWARD(1), .MAX_PENDING(4)) d1 (
        .clk(clk), .rst(rst), .raddr_i(raddr), .rdata_o(rdata1), .rbusy_o(rbusy1),
        .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
        .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b),
        .reserve_valid_i(rsv_valid), .reserve_ready_o(ready1), .reserve_addr_i(rsv_addr),
        .reserve_pair_i(rsv_pair), .pending_cnt_o(cnt1), .err_o(err1));

    function automatic logic [31:0] actual(input int d, input int s, input int p);
        case (s)
            RD:      return d == 0 ? rdata0[p] : rdata1[p];
            BZ:      return 32'(d == 0 ? rbusy0[p] : rbusy1[p]);
            RDY:     return 32'(d == 0 ? ready0 : ready1);
            CNT:     return 32'(d == 0 ? cnt0 : cnt1);
            default: return 32'(d == 0 ? err0 : err1);
        endcase
    endfunction

    // Monitor: compares every expectation tagged with the current cycle, away from the edge
    always @(negedge clk) begin
        while (q.size() != 0 && q[0].cyc <= cyc) begin
            chk_t c;
            logic [31:0] a;
            c = q.pop_front();
            a = actual(c.dut, c.sel, c.port);
            total++;
            if (a !== c.exp) begin
                bad++;
                $display("FAIL %s dut%0d: got %h expected %h (cycle %0d)", c.name, c.dut, a, c.exp, c.cyc);
            end
        end
    end

    task automatic ex(input string n, input int d, input int s, input int p, input logic [31:0] e);
        if (d != 1) q.push_back('{n, 0, s, p, e, cyc});
        if (d != 0) q.push_back('{n, 1, s, p, e, cyc});
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        we_a = 1'b0;
        we_b = '0;
        rsv_valid = 1'b0;
        rsv_pair = 1'b0;
    endtask

    task automatic wb(input logic [5:0] a, input logic [31:0] d);
        we_b = 2'b01; waddr_b = a; wdata_b[0] = d;
    endtask

    task automatic rsv(input logic [5:0] a, input logic p);
        rsv_valid = 1'b1; rsv_addr = a; rsv_pair = p;
    endtask

    initial begin
        nxt();
        ex("rst_ready", 2, RDY, 0, 0); ex("rst_cnt", 2, CNT, 0, 0); ex("rst_err", 2, ERR, 0, 0);
        nxt(); rst = 1'b0;
        // Port A write and x0 write
        nxt(); we_a = 1; waddr_a = 5; wdata_a = 32'hDEADBEEF; raddr[0] = 5;
        ex("x5_same_cycle_nofwd", 0, RD, 0, 0); ex("x5_same_cycle_fwd", 1, RD, 0, 32'hDEADBEEF);
        nxt(); we_a = 1; waddr_a = 0; wdata_a = 1; raddr[1] = 0;
        ex("x5_read", 2, RD, 0, 32'hDEADBEEF); ex("x0_fwd", 2, RD, 1, 0);
        nxt();
        ex("x0_read", 2, RD, 1, 0); ex("err_clean", 2, ERR, 0, 0);
        // Reserve x7, then write it back on port B
        nxt(); rsv(7, 0);
        ex("rsv_x7_ready", 2, RDY, 0, 1);
        nxt(); wb(7, 32'h12345678); raddr[2] = 7;
        ex("x7_cnt1", 2, CNT, 0, 1); ex("x7_busy_nofwd", 0, BZ, 2, 1); ex("x7_busy_fwd", 1, BZ, 2, 0);
        ex("x7_data_nofwd", 0, RD, 2, 0); ex("x7_data_fwd", 1, RD, 2, 32'h12345678);
        nxt();
        ex("x7_data", 2, RD, 2, 32'h12345678); ex("x7_busy_clear", 2, BZ, 2, 0);
        ex("x7_cnt0", 2, CNT, 0, 0); ex("x7_err", 2, ERR, 0, 0);
        // Pair reservation and pair write at x10
        nxt(); rsv(10, 1); raddr[0] = 10; raddr[1] = 11; raddr[2] = 12;
        ex("pair_ready", 2, RDY, 0, 1);
        nxt();
        ex("pair_cnt2", 2, CNT, 0, 2); ex("pair_busy10", 2, BZ, 0, 1); ex("pair_busy11", 2, BZ, 1, 1);
        nxt(); we_b = 2'b11; waddr_b = 10; wdata_b[0] = 32'hA; wdata_b[1] = 32'hB;
        ex("pair_cnt_pre", 2, CNT, 0, 2);
        nxt(); rsv(11, 1);
        ex("pair_x10", 2, RD, 0, 32'hA); ex("pair_x11", 2, RD, 1, 32'hB);
        ex("pair_cnt0", 2, CNT, 0, 0); ex("pair_err", 2, ERR, 0, 0);
        nxt();
        ex("odd_pair_cnt1", 2, CNT, 0, 1); ex("odd_pair_x10", 2, BZ, 0, 0);
        ex("odd_pair_x11", 2, BZ, 1, 1); ex("odd_pair_x12", 2, BZ, 2, 0);
        nxt(); wb(11, 32'h11);
        nxt();
        ex("x11_clear_cnt", 2, CNT, 0, 0); ex("x11_clear_err", 2, ERR, 0, 0);
        // Fill the scoreboard
        for (int r = 1; r <= 4; r++) begin
            nxt(); rsv(6'(r), 0);
            ex("fill_ready", 2, RDY, 0, 1);
        end
        nxt(); rsv(6, 0); wb(2, 32'h22);
        ex("full_cnt4", 2, CNT, 0, 4); ex("full_refuse", 2, RDY, 0, 0);
        nxt(); rsv(6, 0);
        ex("after_clear_cnt3", 2, CNT, 0, 3); ex("after_clear_ready", 2, RDY, 0, 1);
        nxt(); rsv_addr = 8; raddr[0] = 6; raddr[1] = 2;
        ex("refull_cnt4", 2, CNT, 0, 4); ex("refull_ready", 2, RDY, 0, 0);
        ex("x6_busy", 2, BZ, 0, 1); ex("x2_data", 2, RD, 1, 32'h22); ex("x2_busy", 2, BZ, 1, 0);
        ex("full_err", 2, ERR, 0, 0);
        nxt(); rsv_addr = 6;
        ex("busy_target_ready", 2, RDY, 0, 0);
        nxt(); wb(1, 32'h111);
        nxt(); wb(4, 32'h444);
        nxt(); rsv(9, 0);
        ex("x9_ready", 2, RDY, 0, 1);
        // Simultaneous A and B writes to busy x9
        nxt(); we_a = 1; waddr_a = 9; wdata_a = 32'h1; wb(9, 32'h2); raddr[0] = 9;
        ex("ab_cnt3", 2, CNT, 0, 3); ex("ab_data_nofwd", 0, RD, 0, 0); ex("ab_data_fwd", 1, RD, 0, 32'h2);
        ex("ab_busy_nofwd", 0, BZ, 0, 1); ex("ab_busy_fwd", 1, BZ, 0, 0); ex("ab_err_pre", 2, ERR, 0, 0);
        nxt();
        ex("ab_err", 2, ERR, 0, 1); ex("ab_cnt2", 2, CNT, 0, 2); ex("ab_x9", 2, RD, 0, 32'h2);
        // Asynchronous reset mid-stream
        nxt(); wb(3, 32'h55);
        nxt(); rsv(12, 0);
        nxt(); rsv(13, 0);
        nxt(); rsv_addr = 20; raddr[0] = 3; raddr[1] = 6; raddr[2] = 5;
        ex("pre_rst_cnt3", 2, CNT, 0, 3); ex("pre_rst_x3", 2, RD, 0, 32'h55);
        ex("pre_rst_busy6", 2, BZ, 1, 1); ex("pre_rst_ready", 2, RDY, 0, 1);
        nxt();
        ex("rst_cnt0", 2, CNT, 0, 0); ex("rst_ready0", 2, RDY, 0, 0); ex("rst_x3", 2, RD, 0, 0);
        ex("rst_busy6", 2, BZ, 1, 0); ex("rst_err0", 2, ERR, 0, 0); ex("rst_x5", 2, RD, 2, 0);
        #1 rst = 1'b1;
        nxt();
        ex("rst_hold_ready", 2, RDY, 0, 0);
        nxt(); rst = 1'b0;
        ex("post_rst_ready", 2, RDY, 0, 1); ex("post_rst_x5", 2, RD, 2, 0); ex("post_rst_x3", 2, RD, 0, 0);
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cv32e40px_register_file_sb.md
# cv32e40px_register_file_sb

Parametrised successor of the core's flip-flop register file. It adds a configurable number of read ports, optional same-cycle write-to-read forwarding, and a per-register pending-write scoreboard that reserves destinations of offloaded (X-interface) instructions until their results return on write port B. It sits in the ID stage: the decoder reads operands and busy flags, and the coprocessor issue logic reserves destinations through a valid/ready handshake.

## Interface
- ADDR_WIDTH, 6, register address width; bit ADDR_WIDTH-1 selects the FP bank
- DATA_WIDTH, 32, register width
- FPU, 0, 1 instantiates the FP bank
- ZFINX, 0, 1 suppresses the FP bank even when FPU=1
- NUM_READ, 3, number of read ports (1..4)
- X_DUALWRITE, 0, 1 enables pair writes on port B
- FORWARD, 0, 1 forwards same-cycle writes to read data
- MAX_PENDING, 4, maximum number of simultaneously busy registers (1..NUM_TOT)
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- raddr_i  in  NUM_READ x ADDR_WIDTH  read addresses
- rdata_o  out  NUM_READ x DATA_WIDTH  read data
- rbusy_o  out  NUM_READ  addressed register has a pending write
- waddr_a_i / wdata_a_i / we_a_i  in  ADDR_WIDTH / DATA_WIDTH / 1  core write-back port A
- waddr_b_i  in  ADDR_WIDTH  port B address (even for pair writes)
- wdata_b_i  in  (X_DUALWRITE+1) x DATA_WIDTH  port B data; [1] targets waddr_b_i+1
- we_b_i  in  X_DUALWRITE+1  port B enables
- reserve_valid_i / reserve_ready_o  in / out  1 / 1  reservation handshake
- reserve_addr_i  in  ADDR_WIDTH  destination to reserve
- reserve_pair_i  in  1  also reserve reserve_addr_i+1 (X_DUALWRITE=1 only)
- pending_cnt_o  out  $clog2(MAX_PENDING+1)  number of busy registers
- err_o  out  1  sticky protocol-error flag

## Operation
- NUM_TOT = 2^ADDR_WIDTH if FPU=1 and ZFINX=0, else 2^(ADDR_WIDTH-1). Without the FP bank, FP-bank reads return 0, and FP-bank writes and reservations are ignored.
- Integer x0 reads 0; writes to it are ignored; reserving it completes the handshake with no effect. FP f0 is an ordinary register.
- Write priority per register: port B over port A. Pair write: we_b_i[0] and we_b_i[1] with an even waddr_b_i write both registers in the same cycle.
- Scoreboard: one busy bit per register.
  - A reservation handshake (valid & ready) sets the target bit. With a pair request on an even address, it sets both bits. reserve_pair_i with an odd address, or with X_DUALWRITE=0, is treated as a single reservation.
  - A port B write clears the busy bit of every register it writes, including a pair write.
  - A port A write never clears a busy bit.
- reserve_ready_o = not rst, AND no target bit already busy, AND pending_cnt + targets ≤ MAX_PENDING. The number of targets is 1 or 2, and it is 0 for x0 or an ignored FP target. Bits cleared in the same cycle do not count as freed: ready is computed from registered state only and does not depend on reserve_valid_i.
- pending_cnt_o always equals the population count of the busy bits. Same-cycle set and clear net out correctly.
- err_o sets, and stays set until rst, on any of these:
  - a port B write to a non-busy register;
  - a port A write to a busy register (the write is still performed);
  - a port A and port B write to the same register in the same cycle.
- rbusy_o[k] = busy[raddr_i[k]], and is 0 for x0.
- Forwarding (FORWARD=1): if raddr_i[k] matches a register being written this cycle, rdata_o[k] returns that write data, using port B data if both ports write it. In that case rbusy_o[k] is also 0 when port B is writing the register. With FORWARD=0, read data and busy flags reflect only registered state.

## Timing
- Reads are combinational: rdata_o and rbusy_o follow raddr_i in the same cycle.
- Writes, busy set/clear, pending_cnt_o and err_o update on the rising clk edge after the request. A write issued in cycle n is readable from registered state in cycle n+1.
- A reservation accepted in cycle n gives rbusy_o=1 in cycle n+1. A port B write in cycle n gives rbusy_o=0 in cycle n+1, or in cycle n with FORWARD=1.
- Reset is asserted asynchronously and takes effect immediately mid-operation. During and after reset:
  - all registers are 0; busy bits, pending_cnt_o and err_o are 0;
  - reserve_ready_o is 0 while rst is high;
  - rdata_o reads 0 for every address.
- Full condition: when pending_cnt_o=MAX_PENDING, reserve_ready_o stays 0 until a port B write's clear takes effect at the next edge.

## Test plan
- Reset, then a port A write of x5=0xDEADBEEF in cycle 0 → x5 reads 0xDEADBEEF at cycle 1 (FORWARD=0); x0 write of 0x1 still reads 0.
- Reserve x7, then on the next cycle issue a port B write x7=0x12345678 → rbusy_o=1 and pending_cnt_o=1 for one cycle; afterwards busy clears, the count returns to 0 and err_o stays 0.
- X_DUALWRITE=1: pair reserve at x10, then a pair write 0xA/0xB → x10=0xA and x11=0xB, pending count goes 2→0; a pair reserve at x11 sets only x11.
- MAX_PENDING=4: reserve x1-x4 → ready drops at count 4. A port B write to x2 together with a reserve request for x6 in the same cycle → request refused; accepted in the next cycle with the count back at 4.
- FORWARD=1, simultaneous port A (0x1) and port B (0x2) writes to busy x9 → rdata reads 0x2 in the same cycle, rbusy_o=0, err_o=1 next cycle.
- Assert rst mid-stream with 3 regs busy and x3=0x55 → outputs clear immediately: count 0, ready 0, x3 reads 0.
